// File: rtl/spio_link_status_monitor.sv
// Per-device link status conditioner for the status LED generator.
// Produces debounced CONNECTED, stretched ERROR and ACTIVITY strobes.
//
// Ports:
//   CLK_IN, RESET_IN      clock, async active-high reset
//   LINK_UP_IN[i]         raw link-up level (async to CLK_IN)
//   ERROR_PULSE_IN[i]     synchronous error event strobe
//   VLD_IN[i], RDY_IN[i]  observed link handshake
//   CLEAR_IN[i]           synchronous clear of the error counter
//   CONNECTED_OUT[i]      debounced connection level
//   ERROR_OUT[i]          error level held after the last event
//   ACTIVITY_OUT[i]       registered per-transfer strobe
//   ERROR_COUNT_OUT       saturating counters, device i at
//                         [i*ERROR_COUNT_BITS +: ERROR_COUNT_BITS]
module spio_link_status_monitor #(
    parameter int NUM_DEVICES       = 1,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int DEBOUNCE_BITS     = 11,
    parameter int ERROR_HOLD_CYCLES = 150000000,
    parameter int ERROR_HOLD_BITS   = 28,
    parameter int ERROR_COUNT_BITS  = 8
) (
    input  logic                                   CLK_IN,
    input  logic                                   RESET_IN,
    input  logic [NUM_DEVICES-1:0]                 LINK_UP_IN,
    input  logic [NUM_DEVICES-1:0]                 ERROR_PULSE_IN,
    input  logic [NUM_DEVICES-1:0]                 VLD_IN,
    input  logic [NUM_DEVICES-1:0]                 RDY_IN,
    input  logic [NUM_DEVICES-1:0]                 CLEAR_IN,
    output logic [NUM_DEVICES-1:0]                 CONNECTED_OUT,
    output logic [NUM_DEVICES-1:0]                 ERROR_OUT,
    output logic [NUM_DEVICES-1:0]                 ACTIVITY_OUT,
    output logic [NUM_DEVICES*ERROR_COUNT_BITS-1:0] ERROR_COUNT_OUT
);

    typedef enum logic [1:0] {
        DOWN    = 2'd0,
        RISING  = 2'd1,
        UP      = 2'd2,
        FALLING = 2'd3
    } link_state_e;

    localparam logic [DEBOUNCE_BITS-1:0] DB_LOAD =
        DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [ERROR_HOLD_BITS-1:0] HOLD_LOAD =
        ERROR_HOLD_BITS'(ERROR_HOLD_CYCLES);

    for (genvar i = 0; i < NUM_DEVICES; i++) begin : g_dev

        logic [1:0]                  sync_q;
        logic                        link_up_s;
        link_state_e                 state_q;
        link_state_e                 state_d;
        logic [DEBOUNCE_BITS-1:0]    cnt_q;
        logic [DEBOUNCE_BITS-1:0]    cnt_d;
        logic                        drop_d;
        logic                        drop_q;
        logic                        connected;
        logic                        err_evt;
        logic [ERROR_HOLD_BITS-1:0]  hold_q;
        logic [ERROR_COUNT_BITS-1:0] ecnt_q;
        logic                        act_q;

        // Two-flop synchroniser for the asynchronous link level.
        always_ff @(posedge CLK_IN or posedge RESET_IN) begin
            if (RESET_IN) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], LINK_UP_IN[i]};
            end
        end

        assign link_up_s = sync_q[1];

        always_ff @(posedge CLK_IN or posedge RESET_IN) begin
            if (RESET_IN) begin
                state_q <= DOWN;
                cnt_q   <= '0;
                drop_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                drop_q  <= drop_d;
            end
        end

        // Debounce: the level must hold for the whole window
        // before the connected state flips either way.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            drop_d  = 1'b0;
            unique case (state_q)
                DOWN: begin
                    if (link_up_s) begin
                        state_d = RISING;
                        cnt_d   = DB_LOAD;
                    end
                end
                RISING: begin
                    if (!link_up_s) begin
                        state_d = DOWN;
                    end else if (cnt_q == '0) begin
                        state_d = UP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                UP: begin
                    if (!link_up_s) begin
                        state_d = FALLING;
                        cnt_d   = DB_LOAD;
                    end
                end
                FALLING: begin
                    if (link_up_s) begin
                        state_d = UP;
                    end else if (cnt_q == '0) begin
                        state_d = DOWN;
                        drop_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = DOWN;
                end
            endcase
        end

        assign connected = (state_q == UP) || (state_q == FALLING);

        // The drop flag is registered, so a lost link reports its
        // error on the cycle after CONNECTED falls.
        assign err_evt = ERROR_PULSE_IN[i] | drop_q;

        always_ff @(posedge CLK_IN or posedge RESET_IN) begin
            if (RESET_IN) begin
                hold_q <= '0;
            end else if (err_evt) begin
                hold_q <= HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
        end

        // Clear wins over the old value but not over a same-cycle
        // event, which still counts as one.
        always_ff @(posedge CLK_IN or posedge RESET_IN) begin
            if (RESET_IN) begin
                ecnt_q <= '0;
            end else if (CLEAR_IN[i]) begin
                ecnt_q <= err_evt ? ERROR_COUNT_BITS'(1) : '0;
            end else if (err_evt && (ecnt_q != '1)) begin
                ecnt_q <= ecnt_q + 1'b1;
            end
        end

        always_ff @(posedge CLK_IN or posedge RESET_IN) begin
            if (RESET_IN) begin
                act_q <= 1'b0;
            end else begin
                act_q <= VLD_IN[i] & RDY_IN[i] & connected;
            end
        end

        assign CONNECTED_OUT[i] = connected;
        assign ERROR_OUT[i]     = (hold_q != '0);
        assign ACTIVITY_OUT[i]  = act_q;
        assign ERROR_COUNT_OUT[i*ERROR_COUNT_BITS +: ERROR_COUNT_BITS] =
            ecnt_q;
    end

endmodule
